sram_read_unit: RTL and testbench

Sequential SRAM reader, the read-side counterpart of the UART-to-SRAM write path. After `sram_read_start`, it reads `N_WORDS` consecutive 16-bit words from SRAM address 0 upward. Each word is split into two bytes, high byte first, matching the write path's packing order. Bytes are delivered through a valid/ready handshake to a downstream consumer such as the frame renderer or the UART transmitter.

---
 rtl/sram_pkg.sv | 19 +
 rtl/sram_read_unit_if.sv | 28 ++
 rtl/sram_word_to_byte.sv | 42 ++++
 rtl/sram_read_unit.sv | 125 ++++++++++++
 tb/tb_sram_read_unit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared SRAM constants and the read-side state type, used by both the read and write paths.
package sram_pkg;

    localparam int unsigned SRAM_ADDR_W = 19;
    localparam int unsigned SRAM_DATA_W = 16;
    localparam int unsigned SRAM_CNT_W  = 20;
    localparam int unsigned SRAM_BYTE_W = 8;
    localparam int unsigned SRAM_LAT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HI,
        ST_LO,
        ST_FINISH
    } sram_rd_state_e;

endpackage

// File: rtl/sram_read_unit_if.sv
// SRAM read port plus outgoing byte stream of the sequential SRAM reader.
interface sram_read_unit_if;
    import sram_pkg::*;

    logic                   sram_read_selec;
    logic                   sram_read_read;
    logic                   sram_read_write;
    logic [SRAM_ADDR_W-1:0] sram_read_addr;
    logic [SRAM_DATA_W-1:0] sram_read_data;
    logic [SRAM_BYTE_W-1:0] byte_o;
    logic                   byte_valid;
    logic                   byte_ready;

    // Reader side: drives the SRAM strobes and the byte stream.
    modport master (
        output sram_read_selec, sram_read_read, sram_read_write, sram_read_addr,
        output byte_o, byte_valid,
        input  sram_read_data, byte_ready
    );

    // SRAM controller and byte consumer side.
    modport slave (
        input  sram_read_selec, sram_read_read, sram_read_write, sram_read_addr,
        input  byte_o, byte_valid,
        output sram_read_data, byte_ready
    );

endinterface

// File: rtl/sram_word_to_byte.sv
// Word register that presents a 16-bit word as two bytes, high byte first,
// over a valid/ready handshake. The word is shifted left a byte per transfer,
// so byte_o is always a register slice and drops to 0 after the low byte.
module sram_word_to_byte
    import sram_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic [SRAM_DATA_W-1:0] word_i,
    input  logic                   byte_ready_i,
    output logic [SRAM_BYTE_W-1:0] byte_o,
    output logic                   byte_valid_o,
    output logic                   xfer_c_o
);

    logic [SRAM_DATA_W-1:0] word_q;
    logic                   valid_q;
    logic                   lo_q;

    assign xfer_c_o     = valid_q & byte_ready_i;
    assign byte_o       = word_q[SRAM_DATA_W-1 -: SRAM_BYTE_W];
    assign byte_valid_o = valid_q;

    // Load on the last latency cycle, then shift out one byte per transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            lo_q    <= 1'b0;
        end else if (load_i) begin
            word_q  <= word_i;
            valid_q <= 1'b1;
            lo_q    <= 1'b0;
        end else if (xfer_c_o) begin
            word_q  <= {word_q[SRAM_BYTE_W-1:0], SRAM_BYTE_W'(0)};
            valid_q <= ~lo_q;
            lo_q    <= ~lo_q;
        end
    end

endmodule

// File: rtl/sram_read_unit.sv
// Sequential SRAM reader: reads N_WORDS words from address 0 and streams them
// out high byte first. Define SRAM_READ_LOOP_EN to restart playback from
// address 0 after the last byte instead of stopping in FINISH.
module sram_read_unit
    import sram_pkg::*;
#(
    parameter int unsigned N_WORDS  = 100000,
    parameter int unsigned SRAM_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sram_read_start,
    sram_read_unit_if.master      bus,
    output logic                  sram_read_finish,
    output logic [SRAM_CNT_W-1:0] sram_read_count
);

    localparam logic [SRAM_ADDR_W-1:0] ADDR_LAST = SRAM_ADDR_W'(N_WORDS - 1);
    localparam logic [SRAM_LAT_W-1:0]  LAT_LAST  = SRAM_LAT_W'(SRAM_LAT - 1);

    sram_rd_state_e         state_q;
    logic [SRAM_ADDR_W-1:0] addr_q;
    logic [SRAM_LAT_W-1:0]  lat_q;
    logic                   selec_q;
    logic                   read_q;
    logic                   finish_q;
    logic [SRAM_CNT_W-1:0]  count_q;
    logic                   load_c;
    logic                   xfer_c;

    assign load_c = (state_q == ST_WAIT) && (lat_q == LAT_LAST);

    assign bus.sram_read_selec = selec_q;
    assign bus.sram_read_read  = read_q;
    assign bus.sram_read_write = 1'b0;
    assign bus.sram_read_addr  = addr_q;
    assign sram_read_finish    = finish_q;
    assign sram_read_count     = count_q;

    sram_word_to_byte u_w2b (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load_c),
        .word_i       (bus.sram_read_data),
        .byte_ready_i (bus.byte_ready),
        .byte_o       (bus.byte_o),
        .byte_valid_o (bus.byte_valid),
        .xfer_c_o     (xfer_c)
    );

    // Read sequencer: strobes, address, latency counter and byte count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            lat_q    <= '0;
            selec_q  <= 1'b0;
            read_q   <= 1'b0;
            finish_q <= 1'b0;
            count_q  <= '0;
        end else begin
`ifdef SRAM_READ_LOOP_EN
            finish_q <= 1'b0;
`endif
            if (xfer_c) begin
                count_q <= count_q + SRAM_CNT_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (sram_read_start) begin
                        state_q <= ST_REQ;
                        selec_q <= 1'b1;
                        read_q  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    state_q <= ST_WAIT;
                    lat_q   <= '0;
                end
                ST_WAIT: begin
                    lat_q <= lat_q + SRAM_LAT_W'(1);
                    if (lat_q == LAT_LAST) begin
                        state_q <= ST_HI;
                        selec_q <= 1'b0;
                        read_q  <= 1'b0;
                    end
                end
                ST_HI: begin
                    if (xfer_c) begin
                        state_q <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (xfer_c) begin
                        if (addr_q == ADDR_LAST) begin
`ifdef SRAM_READ_LOOP_EN
                            state_q  <= ST_REQ;
                            addr_q   <= '0;
                            count_q  <= '0;
                            finish_q <= 1'b1;
                            selec_q  <= 1'b1;
                            read_q   <= 1'b1;
`else
                            state_q  <= ST_FINISH;
                            finish_q <= 1'b1;
`endif
                        end else begin
                            state_q <= ST_REQ;
                            addr_q  <= addr_q + SRAM_ADDR_W'(1);
                            selec_q <= 1'b1;
                            read_q  <= 1'b1;
                        end
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_FINISH;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_read_unit.sv
// Directed bench for sram_read_unit with N_WORDS=4, SRAM_LAT=2.
module tb_sram_read_unit;
    import sram_pkg::*;

    localparam int unsigned N_WORDS  = 4;
    localparam int unsigned SRAM_LAT = 2;
`ifdef SRAM_READ_LOOP_EN
    localparam logic [31:0] FIN_CNT  = 32'd0;
    localparam logic [31:0] FIN_ADDR = 32'd0;
`else
    localparam logic [31:0] FIN_CNT  = 32'd8;
    localparam logic [31:0] FIN_ADDR = 32'd3;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  finish;
    logic [SRAM_CNT_W-1:0] count;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int reads     = 0;
    int stall_err = 0;
    int rd_cnt    = 0;
    logic [7:0] bytes_q [$];
    int         xcyc_q  [$];
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic       prd = 1'b0;
    logic [7:0] pb = 8'h00;

    sram_read_unit_if bus ();

    sram_read_unit #(.N_WORDS(N_WORDS), .SRAM_LAT(SRAM_LAT)) dut (
        .clk              (clk),
        .rst              (rst),
        .sram_read_start  (start),
        .bus              (bus),
        .sram_read_finish (finish),
        .sram_read_count  (count)
    );

    always #5 clk = ~clk;

    // SRAM model: data only becomes valid after SRAM_LAT cycles of read strobe.
    always @(posedge clk) rd_cnt <= bus.sram_read_read ? rd_cnt + 1 : 0;
    assign bus.sram_read_data = (rd_cnt >= int'(SRAM_LAT))
        ? 16'h1200 + 16'(bus.sram_read_addr) * 16'h0101 : 16'hDEAD;

    // Transfer log, read-strobe counter and stall-stability watcher.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.byte_valid && bus.byte_ready) begin
            bytes_q.push_back(bus.byte_o);
            xcyc_q.push_back(cyc);
        end
        if (bus.sram_read_read && !prd) reads <= reads + 1;
        if (!rst && pv && !pr && (!bus.byte_valid || bus.byte_o !== pb)) stall_err <= stall_err + 1;
        pv  <= bus.byte_valid;
        pr  <= bus.byte_ready;
        pb  <= bus.byte_o;
        prd <= bus.sram_read_read;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_finish(input string tag, input int budget);
        for (int i = 0; i < budget && finish !== 1'b1; i++) @(negedge clk);
        chk(tag, 32'(finish), 32'd1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_state"}, 32'(dut.state_q), 32'(ST_IDLE));
        chk({tag, "_selec"}, 32'(bus.sram_read_selec), 32'd0);
        chk({tag, "_read"},  32'(bus.sram_read_read), 32'd0);
        chk({tag, "_write"}, 32'(bus.sram_read_write), 32'd0);
        chk({tag, "_addr"},  32'(bus.sram_read_addr), 32'd0);
        chk({tag, "_byte"},  32'(bus.byte_o), 32'd0);
        chk({tag, "_valid"}, 32'(bus.byte_valid), 32'd0);
        chk({tag, "_fin"},   32'(finish), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
    endtask

    initial begin
        logic [7:0] exp_b [8];
        int base;
        int rbase;
        int first_v;
        exp_b = '{8'h12, 8'h00, 8'h13, 8'h01, 8'h14, 8'h02, 8'h15, 8'h03};
        rst = 1'b1;
        start = 1'b0;
        bus.byte_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_hold", 32'(dut.state_q), 32'(ST_IDLE));

        // Run 1: ready held high, start dropped after the first byte.
        base = bytes_q.size();
        rbase = reads;
        start = 1'b1;
        bus.byte_ready = 1'b1;
        first_v = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("req_read", 32'(bus.sram_read_read), 32'd1);
                chk("req_selec", 32'(bus.sram_read_selec), 32'd1);
                chk("req_valid", 32'(bus.byte_valid), 32'd0);
            end
            if (bus.byte_valid) begin
                first_v = i;
                break;
            end
        end
        chk("first_valid_lat", 32'(first_v), 32'(2 + SRAM_LAT));
        chk("first_byte", 32'(bus.byte_o), 32'h12);
        @(negedge clk);
        start = 1'b0;
        wait_finish("runA_finish", 100);
        for (int i = 0; i < 8; i++) chk($sformatf("runA_byte%0d", i), 32'(bytes_q[base + i]), 32'(exp_b[i]));
        chk("runA_count", 32'(count), FIN_CNT);
        chk("runA_addr", 32'(bus.sram_read_addr), FIN_ADDR);
        chk("runA_reads", 32'(reads - rbase), 32'd4);
        chk("word_spacing01", 32'(xcyc_q[base + 2] - xcyc_q[base]), 32'(3 + SRAM_LAT));
        chk("word_spacing23", 32'(xcyc_q[base + 6] - xcyc_q[base + 4]), 32'(3 + SRAM_LAT));
`ifdef SRAM_READ_LOOP_EN
        @(negedge clk);
        chk("loop_fin_pulse", 32'(finish), 32'd0);
        chk("loop_rereq", 32'(bus.sram_read_read), 32'd1);
        for (int i = 0; i < 50 && bytes_q.size() < base + 9; i++) @(negedge clk);
        chk("loop_replay_byte", 32'(bytes_q[base + 8]), 32'(exp_b[0]));
`else
        repeat (3) @(negedge clk);
        chk("finish_hold", 32'(finish), 32'd1);
        chk("count_hold", 32'(count), 32'd8);
        chk("finish_valid", 32'(bus.byte_valid), 32'd0);
        chk("finish_byte", 32'(bus.byte_o), 32'd0);
        chk("finish_read", 32'(bus.sram_read_read), 32'd0);
`endif

        // Run 2: random 50% ready backpressure.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        base = bytes_q.size();
        rbase = reads;
        start = 1'b1;
        for (int i = 0; i < 400 && finish !== 1'b1; i++) begin
            bus.byte_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("runB_finish", 32'(finish), 32'd1);
        for (int i = 0; i < 8; i++) chk($sformatf("runB_byte%0d", i), 32'(bytes_q[base + i]), 32'(exp_b[i]));
        chk("runB_stall_stable", 32'(stall_err), 32'd0);
        chk("runB_reads", 32'(reads - rbase), 32'd4);
        chk("runB_count", 32'(count), FIN_CNT);
        bus.byte_ready = 1'b1;

        // Run 3: reset during the latency wait of word 2, then restart.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dut.state_q == ST_WAIT && bus.sram_read_addr == 19'd2) break;
        end
        chk("reach_wait2", 32'(bus.sram_read_addr), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk_zero_outputs("midrst");
        rst = 1'b0;
        base = bytes_q.size();
        @(negedge clk);
        chk("restart_read", 32'(bus.sram_read_read), 32'd1);
        chk("restart_addr", 32'(bus.sram_read_addr), 32'd0);
        wait_finish("runC_finish", 100);
        chk("runC_byte0", 32'(bytes_q[base]), 32'h12);
        chk("runC_byte1", 32'(bytes_q[base + 1]), 32'h00);
        chk("runC_byte7", 32'(bytes_q[base + 7]), 32'h03);
        chk("runC_count", 32'(count), FIN_CNT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
